// File: rtl/sram_port_pkg.sv
// Shared geometry constants for the RW SRAM macro instances and the port grant type.
package sram_port_pkg;

  // Address width / word width / write-mask width per macro instance
  localparam int unsigned DATA_ADDR_W     = 9;
  localparam int unsigned DATA_DATA_W     = 256;
  localparam int unsigned DATA_MASK_W     = 32;

  localparam int unsigned DATA_0_0_ADDR_W = 9;
  localparam int unsigned DATA_0_0_DATA_W = 128;
  localparam int unsigned DATA_0_0_MASK_W = 4;

  localparam int unsigned TAG_ADDR_W      = 6;
  localparam int unsigned TAG_DATA_W      = 88;
  localparam int unsigned TAG_MASK_W      = 4;

  localparam int unsigned TAG_0_ADDR_W    = 6;
  localparam int unsigned TAG_0_DATA_W    = 84;
  localparam int unsigned TAG_0_MASK_W    = 4;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry response buffer holding SRAM read data until the consumer takes it.
module sram_resp_fifo #(
  parameter int unsigned DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    // A push into a full buffer is dropped; the credit logic upstream must prevent it.
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  overflow_check: assert property (@(posedge clock) disable iff (!reset_n)
                                   !(push && (count_q == 2'd2)));

endmodule

// File: rtl/sram_port_arbiter.sv
// Merges a write channel and a read channel onto one SRAM RW port (round-robin) and
// buffers the one-cycle-latency read data behind valid/ready back-pressure.
module sram_port_arbiter
  import sram_port_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned MASK_W     = 4,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic              inflight_q, inflight_d;
  grant_e            last_grant_q, last_grant_d;
  logic [1:0]        count;
  logic [DATA_W-1:0] head;
  logic              rd_ok, grant_rd, grant_wr;
  logic              push, pop;

  always_comb begin
    // Credit: every granted read must have a slot waiting for it.
    rd_ok    = ({1'b0, count} + {2'b00, inflight_q}) < 3'(RESP_DEPTH);
    grant_rd = reset_n && rd_valid && rd_ok && (!wr_valid || (last_grant_q == GRANT_WR));
    grant_wr = reset_n && wr_valid && !grant_rd;

    last_grant_d = last_grant_q;
    if (grant_wr) begin
      last_grant_d = GRANT_WR;
    end else if (grant_rd) begin
      last_grant_d = GRANT_RD;
    end
    inflight_d = grant_rd;

    resp_valid = reset_n && ((count != 2'd0) || inflight_q);
    resp_data  = (count != 2'd0) ? head : sram_rdata;
    // Macro data is only held until the next access, so it is captured unless consumed now.
    push = reset_n && inflight_q && !((count == 2'd0) && resp_ready);
    pop  = resp_valid && resp_ready && (count != 2'd0);
  end

  assign wr_ready   = grant_wr;
  assign rd_ready   = grant_rd;
  assign sram_en    = grant_wr || grant_rd;
  assign sram_wmode = grant_wr;
  assign sram_addr  = grant_rd ? rd_addr : wr_addr;
  assign sram_wmask = grant_wr ? wr_mask : '0;
  assign sram_wdata = wr_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inflight_q   <= 1'b0;
      last_grant_q <= GRANT_WR;
    end else begin
      inflight_q   <= inflight_d;
      last_grant_q <= last_grant_d;
    end
  end

  sram_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (sram_rdata),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and scoreboard checks of sram_port_arbiter against a behavioural RW SRAM model.
module tb_sram_port_arbiter;

  logic         clock;
  logic         reset_n;
  logic         wr_valid, wr_ready;
  logic [8:0]   wr_addr;
  logic [3:0]   wr_mask;
  logic [127:0] wr_data;
  logic         rd_valid, rd_ready;
  logic [8:0]   rd_addr;
  logic         resp_valid, resp_ready;
  logic [127:0] resp_data;
  logic         sram_en, sram_wmode;
  logic [8:0]   sram_addr;
  logic [3:0]   sram_wmask;
  logic [127:0] sram_wdata;
  logic [127:0] sram_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  sram_port_arbiter #(
    .ADDR_W     (9),
    .DATA_W     (128),
    .MASK_W     (4),
    .RESP_DEPTH (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_mask    (wr_mask),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural macro: one-cycle read latency, rdata garbage after a write.
  bit [127:0] mem [512];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < 4; l++) begin
          if (sram_wmask[l]) mem[sram_addr][l*32 +: 32] <= sram_wdata[l*32 +: 32];
        end
        sram_rdata <= {$urandom, $urandom, $urandom, $urandom};
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b1;
    wr_addr = '0; wr_mask = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [3:0] m, input logic [127:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d; rd_valid = 1'b0;
    #2;
    check("write_grant", wr_ready, 1'b1);
    next_cycle();
    wr_valid = 1'b0;
  endtask

  typedef struct {
    logic wv;
    logic rv;
    logic exp_wr;
    logic exp_rd;
    logic exp_rv;
  } vec_t;

  vec_t tbl [6];

  logic [127:0] exp_bp [4];
  logic [127:0] ref_mem [512];
  logic [127:0] sb [$];
  int issued, got;
  logic m_last_wr, e_rd, e_wr;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Contention with consumer ready: R,W,R,W,R,W; resp_valid follows each read.
    tbl[0] = '{1, 1, 0, 1, 0};
    tbl[1] = '{1, 1, 1, 0, 1};
    tbl[2] = '{1, 1, 0, 1, 0};
    tbl[3] = '{1, 1, 1, 0, 1};
    tbl[4] = '{1, 1, 0, 1, 0};
    tbl[5] = '{1, 1, 1, 0, 1};
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;

    // Reset with requests pending
    idle();
    reset_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
    #2;
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_ready", rd_ready, 1'b0);
    check("rst_sram_en", sram_en, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    next_cycle();
    next_cycle();
    idle();
    reset_n = 1'b1;

    // Full write then read-back
    wr_valid = 1'b1; wr_addr = 9'h012; wr_mask = 4'hf; wr_data = {16{8'hA5}};
    #2;
    check("wr_wmode", sram_wmode, 1'b1);
    check("wr_wmask", sram_wmask, 4'hf);
    check("wr_en", sram_en, 1'b1);
    do_write(9'h012, 4'hf, {16{8'hA5}});
    rd_valid = 1'b1; rd_addr = 9'h012;
    #2;
    check("rd_grant", rd_ready, 1'b1);
    check("rd_wmode", sram_wmode, 1'b0);
    check("rd_wmask", sram_wmask, 4'h0);
    check("rd_addr", sram_addr, 9'h012);
    next_cycle();
    rd_valid = 1'b0;
    #2;
    check("rd_resp_valid", resp_valid, 1'b1);
    check("rd_resp_data", resp_data, {16{8'hA5}});
    next_cycle();
    #2;
    check("rd_resp_gone", resp_valid, 1'b0);

    // Partial mask write
    do_write(9'h012, 4'b0101, '0);
    rd_valid = 1'b1; rd_addr = 9'h012;
    #2;
    check("pm_rd_grant", rd_ready, 1'b1);
    next_cycle();
    rd_valid = 1'b0;
    #2;
    check("pm_resp_valid", resp_valid, 1'b1);
    check("pm_resp_data", resp_data, {32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0});
    next_cycle();

    // Back-pressure: four reads with a stalled consumer
    for (int i = 0; i < 4; i++) begin
      exp_bp[i] = {4{32'hB0B0_0000 + 32'(i)}};
      do_write(9'h020 + 9'(i), 4'hf, exp_bp[i]);
    end
    resp_ready = 1'b0; issued = 0; got = 0;
    rd_valid = 1'b1; rd_addr = 9'h020;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (rd_ready) issued++;
      next_cycle();
      rd_addr = 9'h020 + 9'(issued);
    end
    #2;
    check("bp_issued_stalled", 32'(issued), 32'd2);
    check("bp_rd_blocked", rd_ready, 1'b0);
    check("bp_resp_valid", resp_valid, 1'b1);
    resp_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      #2;
      if (rd_ready) issued++;
      if (resp_valid) begin
        check("bp_resp_order", resp_data, exp_bp[got]);
        got++;
      end
      next_cycle();
      rd_addr = 9'h020 + 9'(issued);
      rd_valid = (issued < 4);
    end
    check("bp_all_issued", 32'(issued), 32'd4);
    check("bp_all_returned", 32'(got), 32'd4);
    idle();

    // Reset in the cycle after a read grant
    rd_valid = 1'b1; rd_addr = 9'h021; resp_ready = 1'b0;
    #2;
    check("mr_rd_grant", rd_ready, 1'b1);
    next_cycle();
    rd_valid = 1'b0; reset_n = 1'b0; resp_ready = 1'b1;
    #2;
    check("mr_resp_valid", resp_valid, 1'b0);
    check("mr_sram_en", sram_en, 1'b0);
    next_cycle();
    #2;
    check("mr_outputs", {wr_ready, rd_ready, sram_en, resp_valid}, 4'b0000);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #2;
      check("mr_no_resp", resp_valid, 1'b0);
    end
    next_cycle();

    // Contention table (last_grant is WRITE after the reset above)
    wr_addr = 9'h100; wr_mask = 4'hf; wr_data = '1; rd_addr = 9'h020;
    for (int i = 0; i < 6; i++) begin
      wr_valid = tbl[i].wv; rd_valid = tbl[i].rv;
      #2;
      check("ct_wr_ready", wr_ready, tbl[i].exp_wr);
      check("ct_rd_ready", rd_ready, tbl[i].exp_rd);
      check("ct_resp_valid", resp_valid, tbl[i].exp_rv);
      next_cycle();
    end
    idle();

    // Random traffic against a scoreboard
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    m_last_wr = 1'b1;
    for (int c = 0; c < 400; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      rd_valid = 1'($urandom_range(0, 1));
      resp_ready = ($urandom_range(0, 3) != 0);
      wr_addr = 9'h040 + 9'($urandom_range(0, 15));
      rd_addr = 9'h040 + 9'($urandom_range(0, 15));
      wr_mask = 4'($urandom);
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      #2;
      e_rd = rd_valid && (sb.size() < 2) && (!wr_valid || m_last_wr);
      e_wr = wr_valid && !e_rd;
      check("rnd_rd_ready", rd_ready, e_rd);
      check("rnd_wr_ready", wr_ready, e_wr);
      check("rnd_resp_valid", resp_valid, sb.size() != 0);
      if (resp_ready && sb.size() != 0) begin
        check("rnd_resp_data", resp_data, sb[0]);
        void'(sb.pop_front());
      end
      if (e_wr) begin
        for (int l = 0; l < 4; l++) begin
          if (wr_mask[l]) ref_mem[wr_addr][l*32 +: 32] = wr_data[l*32 +: 32];
        end
        m_last_wr = 1'b1;
      end
      if (e_rd) begin
        sb.push_back(ref_mem[rd_addr]);
        m_last_wr = 1'b0;
      end
      next_cycle();
    end
    idle();
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      #2;
      check("drain_resp_valid", resp_valid, 1'b1);
      check("drain_resp_data", resp_data, sb[0]);
      void'(sb.pop_front());
      next_cycle();
    end
    #2;
    check("drain_empty", resp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Single-port front end for the behavioural RW SRAM macros (data and tag arrays). It merges an independent write channel and read-request channel onto the one RW0 port with round-robin arbitration. It captures the one-cycle-latency read data, which the macro holds only until the next port access, into a 2-entry response buffer with valid/ready back-pressure. It sits directly upstream of the macro and presents registered-safe read responses to the cache pipeline.

Parameters:
ADDR_W, 9, SRAM address width
DATA_W, 128, SRAM word width
MASK_W, 4, write-mask width; lane = DATA_W/MASK_W bits
RESP_DEPTH, 2, response buffer entries; fixed at 2

Ports:
clock  in  1  rising-edge clock, shared with the macro's RW0_clk
reset_n  in  1  synchronous active-low reset
wr_valid  in  1  write request valid
wr_ready  out  1  write accepted this cycle
wr_addr  in  ADDR_W  write address
wr_mask  in  MASK_W  per-lane write enable
wr_data  in  DATA_W  write data
rd_valid  in  1  read request valid
rd_ready  out  1  read accepted this cycle
rd_addr  in  ADDR_W  read address
resp_valid  out  1  read data available
resp_ready  in  1  consumer accepts data
resp_data  out  DATA_W  read data
sram_en  out  1  to RW0_en
sram_wmode  out  1  to RW0_wmode
sram_addr  out  ADDR_W  to RW0_addr
sram_wmask  out  MASK_W  to RW0_wmask
sram_wdata  out  DATA_W  to RW0_wdata
sram_rdata  in  DATA_W  from RW0_rdata

Behaviour:
- Reset: while reset_n=0, all of the following hold: wr_ready=0, rd_ready=0, sram_en=0, resp_valid=0, buffer count=0, inflight=0, last_grant=WRITE (so the first contention goes to read). Any in-flight read at reset is discarded.
- Read eligibility: rd_ok = (count + inflight) < 2.
- Arbitration, combinational each cycle:
  - Only wr_valid: grant write.
  - Only rd_valid with rd_ok: grant read.
  - Both eligible: grant the opposite of last_grant.
  - rd_valid with !rd_ok: the read is ineligible, and a pending write is granted.
- wr_ready=grant_wr; rd_ready=grant_rd. last_grant updates only on a grant.
- SRAM drive:
  - sram_en = grant_wr|grant_rd.
  - sram_wmode = grant_wr.
  - sram_addr = the granted channel's address.
  - sram_wmask/sram_wdata = wr_mask/wr_data. Data is don't-care on reads, but mask is forced to 0 on reads.
- Pipeline: inflight <= grant_rd. The cycle after a read is granted (inflight=1), sram_rdata is valid and is consumed that cycle.
  - If count=0 and resp_ready: the data passes through (resp_valid=1, resp_data=sram_rdata) and is not stored.
  - Otherwise it is enqueued.
- resp_valid = (count>0) | inflight. resp_data = head when count>0, else sram_rdata. Order is strictly the read-grant order.
- Dequeue when resp_valid&resp_ready&count>0. Enqueue and dequeue in the same cycle leave count unchanged.
- The credit rule guarantees no overflow. Any enqueue with count=2 is a design error: assertion, and the data is dropped.
- Ordering: a read granted in a cycle after a write's grant returns the new data. Write-mask lanes with 0 keep their old contents.
- Throughput: one access per cycle. With a stalled consumer, at most 2 reads are outstanding.

Decomposition:
- Package sram_port_pkg:
  - Geometry constants per macro instance: data 9/256/32, data_0_0 9/128/4, tag 6/88/4, tag_0 6/84/4.
  - Grant enum {GRANT_RD, GRANT_WR}.
- Sub-module sram_resp_fifo: 2-entry, DATA_W wide, with push/pop/count, head output and synchronous active-low reset. The arbiter, credit logic and pass-through mux stay in the top.

Test Plan:
- Reset, then a single write: addr=0x012, mask=4'b1111, data=0xA5..A5. Then a read of 0x012 with resp_ready=1 → read granted 1 cycle after the write, resp_valid the next cycle, resp_data=0xA5..A5.
- Partial mask: write 0x012 with mask=4'b0101 and data=all-0x00, then read → lanes 0 and 2 are zero, lanes 1 and 3 are unchanged 0xA5.
- Contention: wr_valid and rd_valid held high for 6 cycles → grants alternate R,W,R,W,R,W, starting with read after reset.
- Back-pressure: resp_ready=0 while 4 reads are queued → exactly 2 rd_ready pulses, then rd_ready=0. Raise resp_ready → responses return in order, and the remaining 2 reads issue.
- Reset mid-operation: assert reset_n=0 in the cycle after a read grant → no response is ever delivered, and all outputs are 0 on the next edge.
- Random read/write traffic against a scoreboard model with random resp_ready → data and order match, and the overflow assertion never fires.
